axil_cmd_master: RTL and testbench

//  Single-outstanding AXI4-Lite master. Turns a simple command stream (read/write, addr, data, strobe)

---
 rtl/axil_pkg.sv | 34 +++
 rtl/axil_cmd_master.sv | 239 +++++++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : axil_pkg                                                       |
// | Purpose   : Shared definitions for the AXI4-Lite command master.           |
// |             AXI response codes, master FSM state encoding and the          |
// |             register-file offsets of the attached slave.                   |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package axil_pkg;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_DECERR  = 2'b11;
  // Watchdog abort reports the same code as DECERR; rsp_timeout disambiguates.
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  // Register-file offsets of the downstream slave
  localparam logic [3:0] REG_CTRL    = 4'h0;
  localparam logic [3:0] REG_STATUS  = 4'h4;
  localparam logic [3:0] REG_SCRATCH = 4'h8;

  // Master FSM state encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_REQ = 3'd1,
    ST_WR_RSP = 3'd2,
    ST_RD_REQ = 3'd3,
    ST_RD_RSP = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage : axil_pkg
`default_nettype wire

// File: rtl/axil_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : axil_cmd_master                                                |
// | Purpose   : Single-outstanding AXI4-Lite master. Converts a command stream |
// |             (write/read, addr, data, strobe) into one AXI4-Lite            |
// |             transaction and returns exactly one response per command.      |
// | Ports     : m_axi_aclk / m_axi_areset   clock, sync active-high reset      |
// |             cmd_*                        command in  (valid/ready)         |
// |             rsp_*                        response out (valid/ready)        |
// |             busy                         FSM not idle                      |
// |             m_axi_aw*/w*/b*/ar*/r*       AXI4-Lite master channels         |
// | Config    : AXIL_MST_TIMEOUT_EN - enables a per-phase watchdog that aborts |
// |             a hung AXI wait after TIMEOUT_CYCLES cycles (resp 2'b11,       |
// |             rsp_timeout=1). Undefined: waits forever, rsp_timeout = 0.     |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES     = 256
) (
  input  logic                            m_axi_aclk,
  input  logic                            m_axi_areset,
  // command stream
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  // response stream
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic                            busy,
  // write address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                      m_axi_awprot,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  // write data channel
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  // write response channel
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  // read address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                      m_axi_arprot,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  // read data channel
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

  state_e                          state_q, state_d;
  logic                            aw_pend_q, aw_pend_d;   // AW not yet handshaked
  logic                            w_pend_q, w_pend_d;     // W not yet handshaked
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]               wstrb_q, wstrb_d;
  logic                            rsp_write_q, rsp_write_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                      rsp_resp_q, rsp_resp_d;
  logic                            rsp_timeout_q, rsp_timeout_d;

`ifdef AXIL_MST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_phase;
  assign wait_phase = (state_q == ST_WR_REQ) || (state_q == ST_WR_RSP) ||
                      (state_q == ST_RD_REQ) || (state_q == ST_RD_RSP);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

  // -------------------------------------------------------------------------
  // Next-state and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    aw_pend_d     = aw_pend_q;
    w_pend_d      = w_pend_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d        = cmd_addr;
          wdata_d       = cmd_wdata;
          wstrb_d       = cmd_wstrb;
          rsp_write_d   = cmd_write;
          rsp_rdata_d   = '0;
          rsp_resp_d    = RESP_OKAY;
          rsp_timeout_d = 1'b0;
          if (cmd_write) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = ST_WR_REQ;
          end else begin
            state_d   = ST_RD_REQ;
          end
        end
      end

      ST_WR_REQ: begin
        // AW and W retire independently; a channel may handshake before,
        // after or in the same cycle as the other.
        if (aw_pend_q && m_axi_awready) aw_pend_d = 1'b0;
        if (w_pend_q && m_axi_wready)   w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d)    state_d   = ST_WR_RSP;
      end

      ST_WR_RSP: begin
        if (m_axi_bvalid) begin
          rsp_resp_d  = m_axi_bresp;
          rsp_rdata_d = '0;
          state_d     = ST_DONE;
        end
      end

      ST_RD_REQ: begin
        if (m_axi_arready) state_d = ST_RD_RSP;
      end

      ST_RD_RSP: begin
        if (m_axi_rvalid) begin
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

`ifdef AXIL_MST_TIMEOUT_EN
    // Watchdog overrides whatever the wait state decided this cycle.
    if (wait_phase && (cnt_q == CNT_W'(TIMEOUT_CYCLES))) begin
      state_d       = ST_DONE;
      aw_pend_d     = 1'b0;
      w_pend_d      = 1'b0;
      rsp_rdata_d   = '0;
      rsp_resp_d    = RESP_TIMEOUT;
      rsp_timeout_d = 1'b1;
    end
    // Counter restarts on every state entry so each wait phase gets its
    // own full budget.
    if ((state_d != state_q) || !wait_phase) cnt_d = '0;
    else                                     cnt_d = cnt_q + 1'b1;
`endif
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state_q       <= ST_IDLE;
      aw_pend_q     <= 1'b0;
      w_pend_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= RESP_OKAY;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      aw_pend_q     <= aw_pend_d;
      w_pend_q      <= w_pend_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

`ifdef AXIL_MST_TIMEOUT_EN
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) cnt_q <= '0;
    else              cnt_q <= cnt_d;
  end
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign cmd_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign rsp_valid     = (state_q == ST_DONE);
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = aw_pend_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = w_pend_q;
  assign m_axi_bready  = (state_q == ST_WR_RSP);

  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = (state_q == ST_RD_REQ);
  assign m_axi_rready  = (state_q == ST_RD_RSP);

endmodule : axil_cmd_master
`default_nettype wire

// File: tb/tb_axil_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_axil_cmd_master                                             |
// | Purpose   : Self-checking bench for axil_cmd_master driving a small        |
// |             behavioural register-file slave (ctrl 0x0, status 0x4 RO,      |
// |             scratch 0x8, others SLVERR). Timeout scenario runs only when   |
// |             AXIL_MST_TIMEOUT_EN is defined.                                |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_axil_cmd_master;
  import axil_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid = 1'b0, bready;
  logic        arvalid, arready, rvalid = 1'b0, rready;
  logic [31:0] wdata, rdata = '0;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = '0, rresp = '0;

  axil_cmd_master #(
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ADDR_WIDTH(4),
    .TIMEOUT_CYCLES    (16)
  ) dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .busy(busy),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready)
  );

  // ---------------- behavioural slave (not reset by rst) ----------------
  logic        hold = 1'b0;                 // 1: slave never accepts AW/W/AR
  logic [31:0] ctrl_reg = 32'hFFFF_FFFF;
  logic [31:0] scratch_reg = 32'h0;
  logic [31:0] status_reg = 32'hA5A5_0001;

  assign awready = awvalid & wvalid & ~hold;
  assign wready  = awvalid & wvalid & ~hold;
  assign arready = arvalid & ~hold;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (awvalid && awready) begin
      bvalid <= 1'b1;
      bresp  <= RESP_OKAY;
      if (awaddr == REG_CTRL)         ctrl_reg    <= merge(ctrl_reg, wdata, wstrb);
      else if (awaddr == REG_SCRATCH) scratch_reg <= merge(scratch_reg, wdata, wstrb);
      else if (awaddr != REG_STATUS)  bresp       <= RESP_SLVERR;
    end else if (bvalid && bready) begin
      bvalid <= 1'b0;
    end
    if (arvalid && arready) begin
      rvalid <= 1'b1;
      rresp  <= RESP_OKAY;
      case (araddr)
        REG_CTRL:    rdata <= ctrl_reg;
        REG_STATUS:  rdata <= status_reg;
        REG_SCRATCH: rdata <= scratch_reg;
        default: begin rdata <= 32'h0; rresp <= RESP_SLVERR; end
      endcase
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issue one command, wait for its response, consume it.
  task automatic run_cmd(input logic wr, input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd,
                         output logic [1:0] rs, output logic to, output logic rw);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    if (!rsp_valid) check("rsp_wait_timeout", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout; rw = rsp_write;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic [1:0]  rs;
  logic        to, rw;

  initial begin
    int n;
    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valids", {28'd0, awvalid, wvalid, arvalid, rsp_valid}, 32'd0);
    check("rst_readies", {30'd0, bready, rready}, 32'd0);
    rst = 1'b0;

    // ---------------- 1: full write then read ----------------
    run_cmd(1'b1, REG_SCRATCH, 32'hDEAD_BEEF, 4'hF, rd, rs, to, rw);
    check("t1_wr_resp", 32'(rs), 32'd0);
    check("t1_wr_rdata", rd, 32'h0);
    check("t1_wr_echo", 32'(rw), 32'd1);
    check("t1_wr_timeout", 32'(to), 32'd0);
    run_cmd(1'b0, REG_SCRATCH, 32'h0, 4'h0, rd, rs, to, rw);
    check("t1_rd_data", rd, 32'hDEAD_BEEF);
    check("t1_rd_resp", 32'(rs), 32'd0);
    check("t1_rd_echo", 32'(rw), 32'd0);

    // ---------------- 2: partial strobe ----------------
    run_cmd(1'b1, REG_SCRATCH, 32'h0000_1234, 4'h3, rd, rs, to, rw);
    run_cmd(1'b0, REG_SCRATCH, 32'h0, 4'h0, rd, rs, to, rw);
    check("t2_strb_merge", rd, 32'hDEAD_1234);

    // ---------------- 3: ctrl/status/unmapped ----------------
    run_cmd(1'b0, REG_CTRL, 32'h0, 4'h0, rd, rs, to, rw);
    check("t3_ctrl", rd, 32'hFFFF_FFFF);
    run_cmd(1'b0, REG_STATUS, 32'h0, 4'h0, rd, rs, to, rw);
    check("t3_status", rd, 32'hA5A5_0001);
    run_cmd(1'b1, REG_STATUS, 32'h0, 4'hF, rd, rs, to, rw);
    run_cmd(1'b0, REG_STATUS, 32'h0, 4'h0, rd, rs, to, rw);
    check("t3_status_ro", rd, 32'hA5A5_0001);
    run_cmd(1'b0, 4'hC, 32'h0, 4'h0, rd, rs, to, rw);
    check("t3_unmapped_resp", 32'(rs), 32'(RESP_SLVERR));

    // ---------------- 4: response back-pressure ----------------
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = REG_SCRATCH; cmd_wstrb = 4'h0;
    @(posedge clk); #1;
    // keep offering a second command (write scratch = 0x55) during the read
    cmd_write = 1'b1; cmd_wdata = 32'h0000_0055; cmd_wstrb = 4'hF;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    check("t4_rsp_valid", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_rdata", rsp_rdata, 32'hDEAD_1234);
      check("t4_hold_cmd_ready", 32'(cmd_ready), 32'd0);
      check("t4_hold_rsp_valid", 32'(rsp_valid), 32'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("t4_next_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("t4_next_busy", 32'(busy), 32'd1);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    check("t4_next_write_echo", 32'(rsp_write), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    run_cmd(1'b0, REG_SCRATCH, 32'h0, 4'h0, rd, rs, to, rw);
    check("t4_second_cmd_data", rd, 32'h0000_0055);

    // ---------------- 5: reset during WR_REQ ----------------
    hold = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = REG_SCRATCH;
    cmd_wdata = 32'h1111_1111; cmd_wstrb = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("t5_aw_w_valid", {30'd0, awvalid, wvalid}, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check("t5_valids_cleared", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
    check("t5_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t5_no_rsp", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    hold = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t5_quiet_rsp", 32'(rsp_valid), 32'd0);
    end
    run_cmd(1'b0, REG_SCRATCH, 32'h0, 4'h0, rd, rs, to, rw);
    check("t5_slave_unchanged", rd, 32'h0000_0055);

`ifdef AXIL_MST_TIMEOUT_EN
    // ---------------- 6: watchdog ----------------
    hold = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = REG_SCRATCH;
    cmd_wdata = 32'h2222_2222; cmd_wstrb = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("t6_latency", 32'(n), 32'd17);
    check("t6_resp", 32'(rsp_resp), 32'd3);
    check("t6_timeout", 32'(rsp_timeout), 32'd1);
    check("t6_rdata", rsp_rdata, 32'h0);
    check("t6_valids_dropped", {30'd0, awvalid, wvalid}, 32'd0);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    hold = 1'b0;
    run_cmd(1'b0, REG_SCRATCH, 32'h0, 4'h0, rd, rs, to, rw);
    check("t6_after_timeout_flag", 32'(to), 32'd0);
    check("t6_after_timeout_data", rd, 32'h0000_0055);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_axil_cmd_master
`default_nettype wire
